// File: rtl/modular_mul_pipe_if.sv
// Handshake bundle for modular_mul_pipe: operation stream in, result stream out,
// plus the side port that loads the Shoup constant pair.
interface modular_mul_pipe_if #(
  parameter int W     = 14,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             k_load;
  logic [W-1:0]     k_in;
  logic [W:0]       k_pre_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_c;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_tag, k_load, k_in, k_pre_in, out_ready,
    output in_ready, out_valid, out_c, out_tag
  );

  modport master (
    output in_valid, in_mode, in_a, in_b, in_tag, k_load, k_in, k_pre_in, out_ready,
    input  in_ready, out_valid, out_c, out_tag
  );
endinterface

// File: rtl/modular_mul_pipe.sv
// Five-stage modular multiplier. Mode 0 reduces A*B with Barrett, mode 1 reduces
// A*K with Shoup using the precomputed K'. Every op carries its own mode, tag and
// constant pair, so modes can mix freely. One global enable stalls the whole pipe.
module modular_mul_pipe #(
  parameter int W     = 14,
  parameter int Q     = 12289,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  modular_mul_pipe_if.slave bus
);
  localparam logic [2*W:0] POW_2W   = (2*W+1)'(1) << (2*W);
  localparam logic [W:0]   MU       = (W+1)'(POW_2W / (2*W+1)'(Q));
  localparam logic [W+1:0] POW_W    = (W+2)'(1) << W;
  localparam logic [W:0]   KPRE_RST = (W+1)'(POW_W / (W+2)'(Q));
  localparam logic [W+1:0] Q_X      = (W+2)'(Q);
  localparam logic [W+1:0] Q2_X     = (W+2)'(2 * Q);

  logic             w_en;
  logic [W-1:0]     r_k;
  logic [W:0]       r_kp;

  logic             r_v1, r_m1;
  logic [W-1:0]     r_a1, r_b1, r_k1;
  logic [W:0]       r_kp1;
  logic [TAG_W-1:0] r_tag1;

  logic             r_v2, r_m2;
  logic [2*W-1:0]   r_p2;
  logic [2*W:0]     r_ak2;
  logic [TAG_W-1:0] r_tag2;

  logic             r_v3, r_m3;
  logic [W+1:0]     r_p3, r_qq3;
  logic [TAG_W-1:0] r_tag3;

  logic             r_v4, r_m4;
  logic [W+1:0]     r_r4;
  logic [TAG_W-1:0] r_tag4;

  logic             r_v5;
  logic [W-1:0]     r_c5;
  logic [TAG_W-1:0] r_tag5;

  logic [2*W+1:0]   w_q2;
  logic [W:0]       w_quot;
  logic [W+1:0]     w_qq;
  logic [W-1:0]     w_c5;

  assign w_en          = ~r_v5 | bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_v5;
  assign bus.out_c     = r_c5;
  assign bus.out_tag   = r_tag5;

  // Constant pair register; loads even during a stall and only affects later accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k  <= W'(1);
      r_kp <= KPRE_RST;
    end else if (bus.k_load) begin
      r_k  <= bus.k_in;
      r_kp <= bus.k_pre_in;
    end
  end

  // Stage 1: capture the op together with the constant pair in force before any load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_m1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_k1   <= '0;
      r_kp1  <= '0;
      r_tag1 <= '0;
    end else if (w_en) begin
      r_v1   <= bus.in_valid;
      r_m1   <= bus.in_mode;
      r_a1   <= bus.in_a;
      r_b1   <= bus.in_b;
      r_k1   <= r_k;
      r_kp1  <= r_kp;
      r_tag1 <= bus.in_tag;
    end
  end

  // Stage 2: full product (A*B or A*K) and the Shoup quotient product A*K'
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_m2   <= 1'b0;
      r_p2   <= '0;
      r_ak2  <= '0;
      r_tag2 <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_m2   <= r_m1;
      r_p2   <= r_m1 ? ((2*W)'(r_a1) * (2*W)'(r_k1)) : ((2*W)'(r_a1) * (2*W)'(r_b1));
      r_ak2  <= (2*W+1)'(r_a1) * (2*W+1)'(r_kp1);
      r_tag2 <= r_tag1;
    end
  end

  // Quotient estimate: Barrett (P>>(W-1))*mu>>(W+1) or Shoup (A*K')>>W, then times Q;
  // the remainder is below 3Q, so only the low W+2 bits of P and q*Q are needed
  always_comb begin
    w_q2 = (2*W+2)'(r_p2 >> (W-1)) * (2*W+2)'(MU);
    if (r_m2) begin
      w_quot = (W+1)'(r_ak2 >> W);
    end else begin
      w_quot = (W+1)'(w_q2 >> (W+1));
    end
    w_qq = (W+2)'(w_quot) * Q_X;
  end

  // Stage 3: register the truncated product and quotient*Q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_m3   <= 1'b0;
      r_p3   <= '0;
      r_qq3  <= '0;
      r_tag3 <= '0;
    end else if (w_en) begin
      r_v3   <= r_v2;
      r_m3   <= r_m2;
      r_p3   <= (W+2)'(r_p2);
      r_qq3  <= w_qq;
      r_tag3 <= r_tag2;
    end
  end

  // Stage 4: partial remainder, wraps correctly modulo 2^(W+2)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v4   <= 1'b0;
      r_m4   <= 1'b0;
      r_r4   <= '0;
      r_tag4 <= '0;
    end else if (w_en) begin
      r_v4   <= r_v3;
      r_m4   <= r_m3;
      r_r4   <= r_p3 - r_qq3;
      r_tag4 <= r_tag3;
    end
  end

  // Final correction: Shoup needs one subtraction of Q, Barrett up to two
  always_comb begin
    w_c5 = W'(r_r4);
    if (r_m4) begin
      if (r_r4 >= Q_X) w_c5 = W'(r_r4 - Q_X);
    end else begin
      if (r_r4 >= Q2_X)     w_c5 = W'(r_r4 - Q2_X);
      else if (r_r4 >= Q_X) w_c5 = W'(r_r4 - Q_X);
    end
  end

  // Stage 5: output register, held while the consumer is not ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v5   <= 1'b0;
      r_c5   <= '0;
      r_tag5 <= '0;
    end else if (w_en) begin
      r_v5   <= r_v4;
      r_c5   <= w_c5;
      r_tag5 <= r_tag4;
    end
  end
endmodule
